// File: rtl/reg_file_banked.sv
// reg_file_banked: banked RV32 integer register file with interrupt shadow banks.
// Bank 0 holds the architectural registers; banks 1..NBANK-1 shadow only the
// register window SHADOW_LO..SHADOW_HI, one bank per interrupt nesting level.
// Owns the nesting-level counter, read-during-write bypass and debug taps.
// Optional feature macro: SHADOW_CLEAR_EN adds a sequencer that zeroes a freshly
// entered shadow bank one register per cycle (Clear_Busy stalls decode meanwhile).
module reg_file_banked #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned NBANK     = 2,
    parameter int unsigned SHADOW_LO = 3,
    parameter int unsigned SHADOW_HI = 4,
    parameter int unsigned DBG_A     = 14,
    parameter int unsigned DBG_B     = 15,
    parameter int unsigned AW        = $clog2(NREG),
    parameter int unsigned LW        = $clog2(NBANK)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AW-1:0]     RS1_Read_Addr,
    input  logic [AW-1:0]     RS2_Read_Addr,
    input  logic [LW-1:0]     RS1_Level,
    input  logic [LW-1:0]     RS2_Level,
    output logic [XLEN-1:0]   RS1_Read_Data,
    output logic [XLEN-1:0]   RS2_Read_Data,
    input  logic [AW-1:0]     RD_Write_Addr,
    input  logic [XLEN-1:0]   RD_Write_Data,
    input  logic [LW-1:0]     WB_Level,
    input  logic              Reg_Write_Enable,
    input  logic              MEM_WB_Freeze,
    input  logic              IRQ_Enter,
    input  logic              IRQ_Exit,
    output logic [LW-1:0]     Cur_Level,
    output logic              Level_Ovf,
    output logic              Clear_Busy,
    output logic [2*XLEN-1:0] led
);

    localparam int unsigned NWIN = SHADOW_HI - SHADOW_LO + 1;
    localparam int unsigned WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int unsigned NSH  = NBANK - 1;
    localparam int unsigned MAXL = NBANK - 1;

    // Levels above the last bank fold onto the last bank.
    function automatic logic [LW-1:0] clamp_lvl(input logic [LW-1:0] l);
        if (32'(l) > MAXL) begin
            return LW'(MAXL);
        end
        return l;
    endfunction

    // True when the address lies in the shadowed window.
    function automatic logic in_win(input logic [AW-1:0] a);
        return (32'(a) >= SHADOW_LO) && (32'(a) <= SHADOW_HI);
    endfunction

    // Bank actually holding register a when viewed from level l.
    function automatic logic [LW-1:0] eff_bank(input logic [AW-1:0] a, input logic [LW-1:0] l);
        return (in_win(a) && (l != '0)) ? l : '0;
    endfunction

    // Offset of a window register inside a shadow bank.
    function automatic logic [WW-1:0] win_idx(input logic [AW-1:0] a);
        return WW'(32'(a) - SHADOW_LO);
    endfunction

    // Shadow storage is indexed from 0 for bank 1.
    function automatic logic [LW-1:0] sh_sel(input logic [LW-1:0] b);
        return LW'(b - LW'(1));
    endfunction

    logic [XLEN-1:0] bank0_q  [NREG];
    logic [XLEN-1:0] shadow_q [NSH][NWIN];

    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          enter_ok;

    logic          wr_commit;
    logic [LW-1:0] wbank;

    logic [AW-1:0]   ra    [2];
    logic [LW-1:0]   rl    [2];
    logic [LW-1:0]   rbank [2];
    logic [XLEN-1:0] rdat  [2];

    assign ra[0] = RS1_Read_Addr;
    assign ra[1] = RS2_Read_Addr;
    assign rl[0] = RS1_Level;
    assign rl[1] = RS2_Level;

    assign wr_commit = Reg_Write_Enable && !MEM_WB_Freeze && (RD_Write_Addr != '0);
    assign wbank     = eff_bank(RD_Write_Addr, clamp_lvl(WB_Level));

    // Non-saturating entry: the level actually advances this cycle.
    assign enter_ok  = IRQ_Enter && !IRQ_Exit && (level_q != LW'(MAXL));

    // Combinational read ports with write-back bypass; storage reads are masked in reset.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rbank[p] = eff_bank(ra[p], clamp_lvl(rl[p]));
            rdat[p]  = '0;
            if (wr_commit && (RD_Write_Addr == ra[p]) && (wbank == rbank[p])) begin
                rdat[p] = RD_Write_Data;
            end else if (RST || (ra[p] == '0)) begin
                rdat[p] = '0;
            end else if (rbank[p] == '0) begin
                rdat[p] = bank0_q[ra[p]];
            end else begin
                rdat[p] = shadow_q[sh_sel(rbank[p])][win_idx(ra[p])];
            end
        end
    end

    assign RS1_Read_Data = rdat[0];
    assign RS2_Read_Data = rdat[1];

    // Next nesting level and sticky overflow flag.
    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q;
        if (IRQ_Enter && !IRQ_Exit) begin
            if (level_q == LW'(MAXL)) begin
                ovf_d = 1'b1;
            end else begin
                level_d = level_q + LW'(1);
            end
        end else if (IRQ_Exit && !IRQ_Enter) begin
            if (level_q != '0) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    // Level counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SHADOW_CLEAR_EN
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_e;

    clr_state_e    state_q;
    logic [LW-1:0] tgt_q;
    logic [AW-1:0] ptr_q;
    logic          clr_we;

    // Clear sequencer: walk the window of the newly entered bank, restart on re-entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            ptr_q   <= AW'(SHADOW_LO);
        end else if (enter_ok) begin
            state_q <= S_CLEAR;
            tgt_q   <= level_q + LW'(1);
            ptr_q   <= AW'(SHADOW_LO);
        end else if (state_q == S_CLEAR) begin
            if (32'(ptr_q) == SHADOW_HI) begin
                state_q <= S_IDLE;
            end else begin
                ptr_q <= ptr_q + AW'(1);
            end
        end
    end

    assign clr_we     = (state_q == S_CLEAR);
    assign Clear_Busy = !RST && (state_q == S_CLEAR);
`else
    assign Clear_Busy = 1'b0;
`endif

    // Bank 0 storage; x0 is never written so it stays zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NREG); i++) begin
                bank0_q[i] <= '0;
            end
        end else if (wr_commit && (wbank == '0)) begin
            bank0_q[RD_Write_Addr] <= RD_Write_Data;
        end
    end

    // Shadow storage; a write-back to the cleared slot overrides the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int b = 0; b < int'(NSH); b++) begin
                for (int w = 0; w < int'(NWIN); w++) begin
                    shadow_q[b][w] <= '0;
                end
            end
        end else begin
`ifdef SHADOW_CLEAR_EN
            if (clr_we) begin
                shadow_q[sh_sel(tgt_q)][win_idx(ptr_q)] <= '0;
            end
`endif
            if (wr_commit && (wbank != '0)) begin
                shadow_q[sh_sel(wbank)][win_idx(RD_Write_Addr)] <= RD_Write_Data;
            end
        end
    end

    assign Cur_Level = RST ? '0 : level_q;
    assign Level_Ovf = !RST && ovf_q;
    assign led       = RST ? '0 : {bank0_q[DBG_A], bank0_q[DBG_B]};

endmodule

// File: tb/tb_reg_file_banked.sv
// Directed self-checking bench for reg_file_banked (default parameters, NBANK=2).
// Clear-sequencer scenarios are selected by SHADOW_CLEAR_EN, matching the RTL build.
module tb_reg_file_banked;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned LW   = 1;

    logic              CLK = 1'b0;
    logic              RST;
    logic [AW-1:0]     RS1_Read_Addr, RS2_Read_Addr;
    logic [LW-1:0]     RS1_Level, RS2_Level;
    logic [XLEN-1:0]   RS1_Read_Data, RS2_Read_Data;
    logic [AW-1:0]     RD_Write_Addr;
    logic [XLEN-1:0]   RD_Write_Data;
    logic [LW-1:0]     WB_Level;
    logic              Reg_Write_Enable, MEM_WB_Freeze;
    logic              IRQ_Enter, IRQ_Exit;
    logic [LW-1:0]     Cur_Level;
    logic              Level_Ovf, Clear_Busy;
    logic [2*XLEN-1:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_banked dut (
        .CLK              (CLK),
        .RST              (RST),
        .RS1_Read_Addr    (RS1_Read_Addr),
        .RS2_Read_Addr    (RS2_Read_Addr),
        .RS1_Level        (RS1_Level),
        .RS2_Level        (RS2_Level),
        .RS1_Read_Data    (RS1_Read_Data),
        .RS2_Read_Data    (RS2_Read_Data),
        .RD_Write_Addr    (RD_Write_Addr),
        .RD_Write_Data    (RD_Write_Data),
        .WB_Level         (WB_Level),
        .Reg_Write_Enable (Reg_Write_Enable),
        .MEM_WB_Freeze    (MEM_WB_Freeze),
        .IRQ_Enter        (IRQ_Enter),
        .IRQ_Exit         (IRQ_Exit),
        .Cur_Level        (Cur_Level),
        .Level_Ovf        (Level_Ovf),
        .Clear_Busy       (Clear_Busy),
        .led              (led)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic [LW-1:0] l);
        RD_Write_Addr    = a;
        RD_Write_Data    = d;
        WB_Level         = l;
        Reg_Write_Enable = 1'b1;
        tick();
        Reg_Write_Enable = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a1, input logic [LW-1:0] l1,
                          input logic [AW-1:0] a2, input logic [LW-1:0] l2);
        RS1_Read_Addr = a1;
        RS1_Level     = l1;
        RS2_Read_Addr = a2;
        RS2_Level     = l2;
        #1;
    endtask

    task automatic pulse(input logic en, input logic ex);
        IRQ_Enter = en;
        IRQ_Exit  = ex;
        tick();
        IRQ_Enter = 1'b0;
        IRQ_Exit  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RS1_Read_Addr = '0; RS2_Read_Addr = '0; RS1_Level = '0; RS2_Level = '0;
        RD_Write_Addr = '0; RD_Write_Data = '0; WB_Level = '0;
        Reg_Write_Enable = 1'b0; MEM_WB_Freeze = 1'b0; IRQ_Enter = 1'b0; IRQ_Exit = 1'b0;
        tick();
        tick();
        n_checks++;
        if (Cur_Level !== 1'b0) begin n_fail++; $display("FAIL reset_level got %h exp 0", Cur_Level); end
        n_checks++;
        if (Level_Ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", Level_Ovf); end
        n_checks++;
        if (Clear_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", Clear_Busy); end
        n_checks++;
        if (led !== 64'h0) begin n_fail++; $display("FAIL reset_led got %h exp 0", led); end
        set_rd(5'd3, 1'b0, 5'd6, 1'b0);
        n_checks++;
        if (RS1_Read_Data !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", RS1_Read_Data); end
        // Bypass still forwards while in reset, but the write itself is discarded.
        RD_Write_Addr = 5'd6; RD_Write_Data = 32'h99; WB_Level = 1'b0; Reg_Write_Enable = 1'b1;
        #1;
        n_checks++;
        if (RS2_Read_Data !== 32'h99) begin n_fail++; $display("FAIL reset_bypass got %h exp 00000099", RS2_Read_Data); end
        tick();
        Reg_Write_Enable = 1'b0;
        RST = 1'b0;
        tick();
        n_checks++;
        if (RS2_Read_Data !== 32'h0) begin n_fail++; $display("FAIL reset_write_dropped got %h exp 0", RS2_Read_Data); end
    endtask

    task automatic test_led();
        wr(5'd14, 32'h1234, 1'b0);
        wr(5'd15, 32'h5678, 1'b0);
        n_checks++;
        if (led !== 64'h0000123400005678) begin n_fail++; $display("FAIL led got %h exp 0000123400005678", led); end
        wr(5'd0, 32'hDEAD, 1'b0);
        RD_Write_Addr = 5'd0; RD_Write_Data = 32'hBEEF; Reg_Write_Enable = 1'b1;
        set_rd(5'd0, 1'b0, 5'd0, 1'b1);
        n_checks++;
        if (RS1_Read_Data !== 32'h0) begin n_fail++; $display("FAIL x0_l0 got %h exp 0", RS1_Read_Data); end
        n_checks++;
        if (RS2_Read_Data !== 32'h0) begin n_fail++; $display("FAIL x0_l1 got %h exp 0", RS2_Read_Data); end
        Reg_Write_Enable = 1'b0;
    endtask

    task automatic test_banks();
        wr(5'd3, 32'hAAAA, 1'b0);
        wr(5'd3, 32'hBBBB, 1'b1);
        wr(5'd5, 32'h5555, 1'b1);
        set_rd(5'd3, 1'b0, 5'd3, 1'b1);
        n_checks++;
        if (RS1_Read_Data !== 32'hAAAA) begin n_fail++; $display("FAIL bank0_x3 got %h exp 0000aaaa", RS1_Read_Data); end
        n_checks++;
        if (RS2_Read_Data !== 32'hBBBB) begin n_fail++; $display("FAIL bank1_x3 got %h exp 0000bbbb", RS2_Read_Data); end
        set_rd(5'd5, 1'b0, 5'd5, 1'b1);
        n_checks++;
        if (RS1_Read_Data !== 32'h5555) begin n_fail++; $display("FAIL alias_x5_l0 got %h exp 00005555", RS1_Read_Data); end
        n_checks++;
        if (RS2_Read_Data !== 32'h5555) begin n_fail++; $display("FAIL alias_x5_l1 got %h exp 00005555", RS2_Read_Data); end
    endtask

    task automatic test_bypass();
        wr(5'd4, 32'h1111, 1'b0);
        RD_Write_Addr = 5'd4; RD_Write_Data = 32'hCAFE; WB_Level = 1'b0;
        Reg_Write_Enable = 1'b1; MEM_WB_Freeze = 1'b1;
        set_rd(5'd4, 1'b1, 5'd4, 1'b0);
        n_checks++;
        if (RS2_Read_Data !== 32'h1111) begin n_fail++; $display("FAIL bypass_frozen got %h exp 00001111", RS2_Read_Data); end
        tick();
        n_checks++;
        if (RS2_Read_Data !== 32'h1111) begin n_fail++; $display("FAIL frozen_no_commit got %h exp 00001111", RS2_Read_Data); end
        MEM_WB_Freeze = 1'b0;
        #1;
        n_checks++;
        if (RS2_Read_Data !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_same_bank got %h exp 0000cafe", RS2_Read_Data); end
        n_checks++;
        if (RS1_Read_Data !== 32'h0) begin n_fail++; $display("FAIL bypass_other_bank got %h exp 0", RS1_Read_Data); end
        tick();
        Reg_Write_Enable = 1'b0;
        #1;
        n_checks++;
        if (RS2_Read_Data !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_committed got %h exp 0000cafe", RS2_Read_Data); end
    endtask

    task automatic test_level();
        pulse(1'b1, 1'b0);
        n_checks++;
        if (Cur_Level !== 1'b1 || Level_Ovf !== 1'b0) begin
            n_fail++; $display("FAIL enter1 got lvl=%h ovf=%b exp lvl=1 ovf=0", Cur_Level, Level_Ovf);
        end
        pulse(1'b1, 1'b0);
        n_checks++;
        if (Cur_Level !== 1'b1 || Level_Ovf !== 1'b1) begin
            n_fail++; $display("FAIL enter_sat got lvl=%h ovf=%b exp lvl=1 ovf=1", Cur_Level, Level_Ovf);
        end
        pulse(1'b1, 1'b1);
        n_checks++;
        if (Cur_Level !== 1'b1) begin n_fail++; $display("FAIL enter_exit got %h exp 1", Cur_Level); end
        pulse(1'b0, 1'b1);
        n_checks++;
        if (Cur_Level !== 1'b0) begin n_fail++; $display("FAIL exit1 got %h exp 0", Cur_Level); end
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        n_checks++;
        if (Cur_Level !== 1'b0 || Level_Ovf !== 1'b1) begin
            n_fail++; $display("FAIL exit_floor got lvl=%h ovf=%b exp lvl=0 ovf=1", Cur_Level, Level_Ovf);
        end
    endtask

`ifdef SHADOW_CLEAR_EN
    task automatic test_clear();
        wr(5'd3, 32'hFFFF, 1'b1);
        wr(5'd4, 32'hFFFF, 1'b1);
        pulse(1'b1, 1'b0);
        n_checks++;
        if (Clear_Busy !== 1'b1 || Cur_Level !== 1'b1) begin
            n_fail++; $display("FAIL clear_busy1 got busy=%b lvl=%h exp busy=1 lvl=1", Clear_Busy, Cur_Level);
        end
        tick();
        n_checks++;
        if (Clear_Busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy2 got %b exp 1", Clear_Busy); end
        tick();
        n_checks++;
        if (Clear_Busy !== 1'b0) begin n_fail++; $display("FAIL clear_done got %b exp 0", Clear_Busy); end
        set_rd(5'd3, 1'b1, 5'd4, 1'b1);
        n_checks++;
        if (RS1_Read_Data !== 32'h0 || RS2_Read_Data !== 32'h0) begin
            n_fail++; $display("FAIL clear_zeroed got x3=%h x4=%h exp 0 0", RS1_Read_Data, RS2_Read_Data);
        end
        set_rd(5'd3, 1'b0, 5'd4, 1'b0);
        n_checks++;
        if (RS1_Read_Data !== 32'hAAAA) begin n_fail++; $display("FAIL clear_bank0_kept got %h exp 0000aaaa", RS1_Read_Data); end
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_clear_reset();
        wr(5'd3, 32'hFFFF, 1'b1);
        pulse(1'b1, 1'b0);
        n_checks++;
        if (Clear_Busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre got %b exp 1", Clear_Busy); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        n_checks++;
        if (Clear_Busy !== 1'b0 || Cur_Level !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort got busy=%b lvl=%h exp busy=0 lvl=0", Clear_Busy, Cur_Level);
        end
        tick();
        n_checks++;
        if (Clear_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_hold got %b exp 0", Clear_Busy); end
    endtask

    task automatic test_clear_collision();
        wr(5'd3, 32'hFFFF, 1'b1);
        wr(5'd4, 32'hFFFF, 1'b1);
        pulse(1'b1, 1'b0);
        tick();
        RD_Write_Addr = 5'd4; RD_Write_Data = 32'h77; WB_Level = 1'b1; Reg_Write_Enable = 1'b1;
        tick();
        Reg_Write_Enable = 1'b0;
        set_rd(5'd3, 1'b1, 5'd4, 1'b1);
        n_checks++;
        if (RS2_Read_Data !== 32'h77) begin n_fail++; $display("FAIL collide_wb_wins got %h exp 00000077", RS2_Read_Data); end
        n_checks++;
        if (RS1_Read_Data !== 32'h0) begin n_fail++; $display("FAIL collide_x3_cleared got %h exp 0", RS1_Read_Data); end
    endtask
`else
    task automatic test_no_clear();
        wr(5'd3, 32'h3333, 1'b1);
        pulse(1'b1, 1'b0);
        n_checks++;
        if (Clear_Busy !== 1'b0 || Cur_Level !== 1'b1) begin
            n_fail++; $display("FAIL noclr_busy got busy=%b lvl=%h exp busy=0 lvl=1", Clear_Busy, Cur_Level);
        end
        tick();
        tick();
        set_rd(5'd3, 1'b1, 5'd3, 1'b0);
        n_checks++;
        if (RS1_Read_Data !== 32'h3333) begin n_fail++; $display("FAIL noclr_stale got %h exp 00003333", RS1_Read_Data); end
        n_checks++;
        if (RS2_Read_Data !== 32'hAAAA) begin n_fail++; $display("FAIL noclr_bank0 got %h exp 0000aaaa", RS2_Read_Data); end
        pulse(1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_led();
        test_banks();
        test_bypass();
        test_level();
`ifdef SHADOW_CLEAR_EN
        test_clear();
        test_clear_reset();
        test_clear_collision();
`else
        test_no_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
